pdc_sched: RTL and testbench

PDC_SCHED -- requirements
Module: pdc_sched

---
 rtl/pdc_sched.sv | 206 ++++++++++++++++++++
 tb/tb_pdc_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdc_sched.sv
// pdc_sched: grants one of two sources a frame slot, forwards FRAME_LEN samples
// into the PDC buffer, waits for the buffer to drain the frame, then inserts an
// idle gap before the next grant. Ties between sources alternate round-robin.
module pdc_sched #(
    parameter int FRAME_LEN = 8640,
    parameter int CNT_W     = 14,
    parameter int GAP_CYC   = 4,
    parameter int DRAIN_TO  = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic signed [7:0] di0,
    input  logic signed [7:0] di1,
    input  logic              di0_vld,
    input  logic              di1_vld,
    output logic              gnt0,
    output logic              gnt1,
    output logic signed [7:0] pdc_di,
    output logic              pdc_di_vld,
    input  logic              pdc_do_vld,
    output logic              busy,
    output logic              frame_src,
    output logic              frame_done,
    output logic              err
);

    localparam int TO_W  = $clog2(DRAIN_TO + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(DRAIN_TO - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               frame_src_q, frame_src_d;
    logic               last_src_q, last_src_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic signed [7:0]  pdc_di_q, pdc_di_d;
    logic               pdc_di_vld_q, pdc_di_vld_d;
    logic               frame_done_q, frame_done_d;
    logic               err_q, err_d;

    logic               sel_src_s;
    logic signed [7:0]  src_di_s;
    logic               src_vld_s;

    // Source selection and granted-source data mux; a tie goes to the source
    // that did not own the previous frame.
    always_comb begin
        sel_src_s = (req0 && req1) ? ~last_src_q : req1;
        src_di_s  = frame_src_q ? di1 : di0;
        src_vld_s = frame_src_q ? di1_vld : di0_vld;
    end

    // Next-state, counter and output computation for the frame scheduler
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        to_cnt_d     = to_cnt_q;
        frame_src_d  = frame_src_q;
        last_src_d   = last_src_q;
        pdc_di_d     = 8'sd0;
        pdc_di_vld_d = 1'b0;
        frame_done_d = 1'b0;

        // A drained sample reported while no frame is draining is a protocol error.
        if (pdc_do_vld && (state_q != S_DRAIN)) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d     = S_FILL;
                    frame_src_d = sel_src_s;
                    last_src_d  = sel_src_s;
                    wr_cnt_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (src_vld_s) begin
                    pdc_di_d     = src_di_s;
                    pdc_di_vld_d = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d  = S_DRAIN;
                        rd_cnt_d = '0;
                        to_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end else if (wr_cnt_q != '0) begin
                    // Stream broke mid-frame: the PDC sees the gap and restarts.
                    err_d     = 1'b1;
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    // Nothing sent yet: keep waiting for the first sample.
                    state_d = S_FILL;
                end
            end
            S_DRAIN: begin
                if (pdc_do_vld && (rd_cnt_q == LAST_IDX)) begin
                    rd_cnt_d     = FRAME_CNT;
                    frame_done_d = 1'b1;
                    state_d      = S_GAP;
                    gap_cnt_d    = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d     = 1'b1;
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (pdc_do_vld && (rd_cnt_q == FRAME_CNT)) begin
                        err_d = 1'b1;
                    end else if (pdc_do_vld) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Grants and busy follow the next state so they are registered with it.
        gnt0_d = (state_d == S_FILL) && !frame_src_d;
        gnt1_d = (state_d == S_FILL) && frame_src_d;
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            to_cnt_q     <= '0;
            frame_src_q  <= 1'b0;
            last_src_q   <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            busy_q       <= 1'b0;
            pdc_di_q     <= 8'sd0;
            pdc_di_vld_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            to_cnt_q     <= to_cnt_d;
            frame_src_q  <= frame_src_d;
            last_src_q   <= last_src_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            busy_q       <= busy_d;
            pdc_di_q     <= pdc_di_d;
            pdc_di_vld_q <= pdc_di_vld_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign pdc_di     = pdc_di_q;
    assign pdc_di_vld = pdc_di_vld_q;
    assign busy       = busy_q;
    assign frame_src  = frame_src_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pdc_sched.sv
// Scoreboard bench for pdc_sched with FRAME_LEN=16, GAP_CYC=4, DRAIN_TO=40.
module tb_pdc_sched;

    localparam int FL  = 16;
    localparam int GAP = 4;
    localparam int DTO = 40;

    localparam logic [7:0] EV_DONE = 8'h44;
    localparam logic [7:0] EV_ERR  = 8'h45;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1;
    logic signed [7:0] di0, di1;
    logic              di0_vld, di1_vld;
    logic              gnt0, gnt1;
    logic signed [7:0] pdc_di;
    logic              pdc_di_vld;
    logic              pdc_do_vld;
    logic              busy, frame_src, frame_done, err;

    int checks = 0;
    int fails  = 0;
    int gnt_cyc = 0;

    logic [7:0] exp_data[$];
    logic       exp_gnt[$];
    logic [7:0] exp_evt[$];

    pdc_sched #(
        .FRAME_LEN(FL),
        .CNT_W(5),
        .GAP_CYC(GAP),
        .DRAIN_TO(DTO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .req1(req1),
        .di0(di0),
        .di1(di1),
        .di0_vld(di0_vld),
        .di1_vld(di1_vld),
        .gnt0(gnt0),
        .gnt1(gnt1),
        .pdc_di(pdc_di),
        .pdc_di_vld(pdc_di_vld),
        .pdc_do_vld(pdc_do_vld),
        .busy(busy),
        .frame_src(frame_src),
        .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        fails++;
        $display("FAIL %s actual=%0d required=none", name, act);
    endtask

    // Monitor: pops the scoreboard queues whenever the DUT presents output.
    task automatic monitor();
        logic prev_g;
        logic [7:0] e;
        prev_g = 1'b0;
        forever begin
            @(negedge clk);
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            if (gnt0 || gnt1) gnt_cyc++;
            if ((gnt0 || gnt1) && !prev_g) begin
                if (exp_gnt.size() == 0) fail_now("gnt_unexpected", {31'd0, gnt1});
                else begin
                    logic s;
                    s = exp_gnt.pop_front();
                    chk("gnt_src", {31'd0, gnt1}, {31'd0, s});
                    chk("frame_src", {31'd0, frame_src}, {31'd0, s});
                end
            end
            prev_g = gnt0 || gnt1;
            if (pdc_di_vld) begin
                if (exp_data.size() == 0) fail_now("pdc_di_unexpected", {24'd0, pdc_di});
                else begin
                    e = exp_data.pop_front();
                    chk("pdc_di", {24'd0, pdc_di}, {24'd0, e});
                end
            end else begin
                chk("pdc_di_zero", {24'd0, pdc_di}, 32'd0);
            end
            if (frame_done) begin
                if (exp_evt.size() == 0) fail_now("frame_done_unexpected", 1);
                else begin
                    e = exp_evt.pop_front();
                    chk("event_done", {24'd0, EV_DONE}, {24'd0, e});
                end
            end
            if (err) begin
                if (exp_evt.size() == 0) fail_now("err_unexpected", 1);
                else begin
                    e = exp_evt.pop_front();
                    chk("event_err", {24'd0, EV_ERR}, {24'd0, e});
                end
            end
        end
    endtask

    task automatic wait_gnt(input logic exp_src, input logic drop, output logic src, output int waited);
        exp_gnt.push_back(exp_src);
        waited = 0;
        src = exp_src;
        while (!(gnt0 || gnt1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!(gnt0 || gnt1)) fail_now("gnt_timeout", waited);
        else src = gnt1;
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
    endtask

    // Drives n samples on the granted source while the other source toggles noise.
    task automatic send(input logic src, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = base + 8'(i);
            if (src) begin
                di1 = d; di1_vld = 1'b1; di0 = ~d; di0_vld = i[0];
            end else begin
                di0 = d; di0_vld = 1'b1; di1 = ~d; di1_vld = i[0];
            end
            exp_data.push_back(d);
            @(negedge clk);
        end
        di0 = 8'sd0; di1 = 8'sd0; di0_vld = 1'b0; di1_vld = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            pdc_do_vld = 1'b1;
            @(negedge clk);
        end
        pdc_do_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_n);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, exp_n);
    endtask

    task automatic wait_err(input string name, input int exp_n);
        int n;
        n = 0;
        while (!err && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, exp_n);
    endtask

    initial begin
        logic src;
        int   waited;
        int   g0;

        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        di0 = 8'sd0; di1 = 8'sd0; di0_vld = 1'b0; di1_vld = 1'b0;
        pdc_do_vld = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_pdc_di_vld", {31'd0, pdc_di_vld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_src", {31'd0, frame_src}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;

        // Both requests held: grants alternate 0,1,0,1 with a GAP between frames
        req0 = 1'b1; req1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_gnt(f[0], (f == 3), src, waited);
            if (f == 0) chk("first_gnt_latency", waited, 1);
            else chk("rr_gap_cycles", waited, GAP + 1);
            send(src, 8'(40 + 20 * f), FL);
            exp_evt.push_back(EV_DONE);
            drain(FL);
        end
        wait_idle("rr_gap_to_idle", GAP);

        // Single source 0 frame with samples 1..16
        @(negedge clk);
        req0 = 1'b1;
        g0 = gnt_cyc;
        wait_gnt(1'b0, 1'b1, src, waited);
        send(src, 8'd1, FL);
        exp_evt.push_back(EV_DONE);
        drain(FL);
        chk("frame_src_after_done", {31'd0, frame_src}, 32'd0);
        chk("gnt0_high_cycles", gnt_cyc - g0, FL);
        wait_idle("single_gap_to_idle", GAP);

        // Source 1 stream breaks after 7 samples: abort
        @(negedge clk);
        req1 = 1'b1;
        wait_gnt(1'b1, 1'b1, src, waited);
        exp_evt.push_back(EV_ERR);
        send(src, 8'd20, 7);
        @(negedge clk);
        chk("abort_err", {31'd0, err}, 32'd1);
        chk("abort_gnt1_low", {31'd0, gnt1}, 32'd0);
        wait_idle("abort_gap_to_idle", GAP);

        // Drain stalls at 15 of 16: timeout
        @(negedge clk);
        req0 = 1'b1;
        wait_gnt(1'b0, 1'b1, src, waited);
        send(src, 8'd50, FL);
        exp_evt.push_back(EV_ERR);
        drain(FL - 1);
        wait_err("drain_timeout_cycles", DTO - (FL - 1));
        wait_idle("timeout_gap_to_idle", GAP);

        // A 17th drain pulse lands in GAP: err, GAP timing unchanged
        @(negedge clk);
        req1 = 1'b1;
        wait_gnt(1'b1, 1'b1, src, waited);
        send(src, 8'd70, FL);
        exp_evt.push_back(EV_DONE);
        exp_evt.push_back(EV_ERR);
        drain(FL + 1);
        chk("extra_pulse_err", {31'd0, err}, 32'd1);
        wait_idle("extra_pulse_gap_to_idle", GAP - 1);

        // Asynchronous reset with 9 samples accepted
        @(negedge clk);
        req0 = 1'b1;
        wait_gnt(1'b0, 1'b1, src, waited);
        for (int i = 0; i < 9; i++) begin
            di0 = 8'(90 + i); di0_vld = 1'b1;
            exp_data.push_back(8'(90 + i));
            @(negedge clk);
        end
        di0 = 8'sd99;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("async_rst_pdc_di_vld", {31'd0, pdc_di_vld}, 32'd0);
        chk("async_rst_pdc_di", {24'd0, pdc_di}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        di0_vld = 1'b0; di0 = 8'sd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(1'b0, 1'b1, src, waited);
        chk("post_rst_gnt_latency", waited, 1);
        send(src, 8'd110, FL);
        exp_evt.push_back(EV_DONE);
        drain(FL);
        wait_idle("post_rst_gap_to_idle", GAP);

        repeat (3) @(negedge clk);
        chk("data_q_left", exp_data.size(), 32'd0);
        chk("gnt_q_left", exp_gnt.size(), 32'd0);
        chk("evt_q_left", exp_evt.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
